dcache: RTL and testbench

Direct-mapped, write-back data cache answering the memory stage's data requests. It sits between the pipeline's memory-stage signals (dmemREN, dmemWEN, dmemaddr, dmemstore) and the memory controller, and returns dhit/dmemload. On halt it writes back all dirty blocks, stores its hit count to memory, then raises flushed.

---
 rtl/dcache.sv | 195 +++++++++++++++++++
 tb/tb_dcache.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache.sv
// Direct-mapped write-back data cache, 2-word blocks. On halt it flushes every
// dirty frame, stores the hit count to 0x3100, then raises flushed.
module dcache #(
   parameter int unsigned SETS = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        halt,
   input  logic        dmemREN,
   input  logic        dmemWEN,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic        dhit,
   output logic [31:0] dmemload,
   output logic        flushed,
   output logic        dREN,
   output logic        dWEN,
   output logic [31:0] daddr,
   output logic [31:0] dstore,
   input  logic        dwait,
   input  logic [31:0] dload
);
   localparam int unsigned IW = $clog2(SETS);
   localparam int unsigned TW = 32 - IW - 3;
   localparam logic [IW:0] LAST_IDX = (IW+1)'(SETS - 1);
   localparam logic [IW:0] END_IDX  = (IW+1)'(SETS);

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, LD0, LD1, FWB0, FWB1, FNEXT, CNT, DONE
   } stateT;

   stateT state, nextState;

   logic [SETS-1:0] valid, dirty;
   logic [TW-1:0]   tags  [SETS];
   logic [31:0]     word0 [SETS];
   logic [31:0]     word1 [SETS];
   logic [31:0]     hitCount;
   logic            missFlag;
   logic [IW:0]     flushIdx;

   logic [IW-1:0] reqIdx, fIdx;
   logic [TW-1:0] reqTag;
   logic          reqWord, request, tagHit;
   logic          unusedByteOffset;

   assign reqIdx           = dmemaddr[IW+2:3];
   assign reqTag           = dmemaddr[31:IW+3];
   assign reqWord          = dmemaddr[2];
   assign unusedByteOffset = ^dmemaddr[1:0];
   assign fIdx             = flushIdx[IW-1:0];
   assign request          = dmemREN | dmemWEN;
   assign tagHit           = valid[reqIdx] && (tags[reqIdx] == reqTag);

   always_comb begin
      nextState = state;
      dhit      = 1'b0;
      dmemload  = '0;
      flushed   = 1'b0;
      dREN      = 1'b0;
      dWEN      = 1'b0;
      daddr     = '0;
      dstore    = '0;
      unique case (state)
         IDLE: begin
            if (halt) begin
               nextState = FNEXT;
            end else if (request) begin
               if (tagHit) begin
                  dhit     = 1'b1;
                  dmemload = reqWord ? word1[reqIdx] : word0[reqIdx];
               end else if (valid[reqIdx] && dirty[reqIdx]) begin
                  nextState = WB0;
               end else begin
                  nextState = LD0;
               end
            end
         end
         WB0: begin
            dWEN   = 1'b1;
            daddr  = {tags[reqIdx], reqIdx, 3'b000};
            dstore = word0[reqIdx];
            if (!dwait) nextState = WB1;
         end
         WB1: begin
            dWEN   = 1'b1;
            daddr  = {tags[reqIdx], reqIdx, 3'b100};
            dstore = word1[reqIdx];
            if (!dwait) nextState = LD0;
         end
         LD0: begin
            dREN  = 1'b1;
            daddr = {reqTag, reqIdx, 3'b000};
            if (!dwait) nextState = LD1;
         end
         LD1: begin
            dREN  = 1'b1;
            daddr = {reqTag, reqIdx, 3'b100};
            if (!dwait) nextState = IDLE;
         end
         // END_IDX is only reached when the last frame needed a write-back
         FNEXT: begin
            if (flushIdx == END_IDX) begin
               nextState = CNT;
            end else if (valid[fIdx] && dirty[fIdx]) begin
               nextState = FWB0;
            end else if (flushIdx == LAST_IDX) begin
               nextState = CNT;
            end
         end
         FWB0: begin
            dWEN   = 1'b1;
            daddr  = {tags[fIdx], fIdx, 3'b000};
            dstore = word0[fIdx];
            if (!dwait) nextState = FWB1;
         end
         FWB1: begin
            dWEN   = 1'b1;
            daddr  = {tags[fIdx], fIdx, 3'b100};
            dstore = word1[fIdx];
            if (!dwait) nextState = FNEXT;
         end
         CNT: begin
            dWEN   = 1'b1;
            daddr  = 32'h0000_3100;
            dstore = hitCount;
            if (!dwait) nextState = DONE;
         end
         DONE: begin
            flushed = 1'b1;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         valid    <= '0;
         dirty    <= '0;
         hitCount <= '0;
         missFlag <= 1'b0;
         flushIdx <= '0;
         for (int unsigned i = 0; i < SETS; i++) begin
            tags[i]  <= '0;
            word0[i] <= '0;
            word1[i] <= '0;
         end
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (halt) begin
                  flushIdx <= '0;
               end else if (request) begin
                  if (tagHit) begin
                     if (!missFlag) hitCount <= hitCount + 32'd1;
                     missFlag <= 1'b0;
                     if (dmemWEN) begin
                        if (reqWord) word1[reqIdx] <= dmemstore;
                        else         word0[reqIdx] <= dmemstore;
                        dirty[reqIdx] <= 1'b1;
                     end
                  end else begin
                     missFlag <= 1'b1;
                  end
               end
            end
            WB1: if (!dwait) dirty[reqIdx] <= 1'b0;
            LD0: if (!dwait) word0[reqIdx] <= dload;
            LD1: begin
               if (!dwait) begin
                  word1[reqIdx] <= dload;
                  valid[reqIdx] <= 1'b1;
                  tags[reqIdx]  <= reqTag;
                  dirty[reqIdx] <= 1'b0;
               end
            end
            FNEXT: begin
               if (flushIdx != END_IDX && !(valid[fIdx] && dirty[fIdx]))
                  flushIdx <= flushIdx + 1'b1;
            end
            FWB1: begin
               if (!dwait) begin
                  dirty[fIdx] <= 1'b0;
                  flushIdx    <= flushIdx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a word-level cache model predicts memory
// transfers and hit data; a negedge monitor plays memory and checks.
module tb_dcache;
   localparam int unsigned SETS = 8;
   localparam int unsigned IW   = 3;

   logic        CLK = 1'b0;
   logic        nRST, halt, dmemREN, dmemWEN;
   logic [31:0] dmemaddr, dmemstore;
   logic        dhit, flushed, dREN, dWEN, dwait;
   logic [31:0] dmemload, daddr, dstore, dload;

   dcache #(.SETS(SETS)) dut (
      .CLK(CLK), .nRST(nRST), .halt(halt),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } xferT;

   xferT        xq[$];
   logic [31:0] hq[$];
   int          tests = 0;
   int          fails = 0;

   logic [31:0] mem    [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];

   bit          mV [SETS];
   bit          mD [SETS];
   int unsigned mT [SETS];
   logic [31:0] mW [SETS][2];
   int unsigned mHits;

   int waitMode;   // 0 none, 1 random, 2 fixed 4, 3 stall second write-back word
   bit hitSeen;

   function automatic logic [31:0] seedVal(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] memRd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : seedVal(a);
   endfunction

   function automatic logic [31:0] refRd(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : seedVal(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pushX(input logic wr, input logic [31:0] a, input logic [31:0] d);
      xferT x;
      x.wr = wr; x.addr = a; x.data = d;
      xq.push_back(x);
   endtask

   task automatic resetModel();
      for (int i = 0; i < SETS; i++) begin
         mV[i] = 0; mD[i] = 0; mT[i] = 0; mW[i][0] = '0; mW[i][1] = '0;
      end
      mHits = 0;
   endtask

   // Cache behaviour from block/frame arithmetic; ntr = memory transfers needed
   task automatic modelReq(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           output int unsigned ntr);
      int unsigned idx, tag, w;
      logic [31:0] line, vb;
      idx  = (a >> 3) % SETS;
      tag  = a >> (IW + 3);
      w    = (a >> 2) % 2;
      line = a & ~32'h7;
      ntr  = 0;
      if (mV[idx] && mT[idx] == tag) begin
         mHits++;
      end else begin
         if (mV[idx] && mD[idx]) begin
            vb = (mT[idx] * SETS + idx) * 8;
            for (int k = 0; k < 2; k++) begin
               pushX(1'b1, vb + 32'(4 * k), mW[idx][k]);
               refMem[vb + 32'(4 * k)] = mW[idx][k];
            end
            ntr = 2;
         end
         for (int k = 0; k < 2; k++) begin
            pushX(1'b0, line + 32'(4 * k), '0);
            mW[idx][k] = refRd(line + 32'(4 * k));
         end
         ntr += 2;
         mV[idx] = 1; mT[idx] = tag; mD[idx] = 0;
      end
      hq.push_back(mW[idx][w]);
      if (wr) begin
         mW[idx][w] = d;
         mD[idx]    = 1;
      end
   endtask

   // Caller is at posedge+1; returns at posedge+1 with the request dropped
   task automatic doReq(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d, input bit chkLat, input string name);
      int unsigned ntr, lat;
      int cyc;
      modelReq(wen, a, d, ntr);
      lat = (ntr == 0) ? 0 : ntr * ((waitMode == 2) ? 5 : 1) + 1;
      hitSeen  = 0;
      dmemREN  = ren; dmemWEN = wen; dmemaddr = a; dmemstore = d;
      cyc = 0;
      do begin
         @(posedge CLK);
         cyc++;
      end while (!hitSeen && cyc < 300);
      #1;
      if (!hitSeen) begin
         tests++; fails++;
         $display("FAIL %s timeout: got no dhit expected dhit within 300 cycles", name);
      end else if (chkLat) begin
         check(name, 32'(cyc - 1), 32'(lat));
      end
      dmemREN = 0; dmemWEN = 0; hitSeen = 0;
   endtask

   // Memory responder and monitor
   int unsigned waitCnt, waitTarget;
   bit          pend;
   logic        pRen, pWen;
   logic [31:0] pAddr, pStore;

   always @(negedge CLK) begin
      xferT x;
      if (!nRST) begin
         pend  = 0;
         dwait = 0;
      end else begin
         if (dREN || dWEN) begin
            check("dREN/dWEN exclusive", {31'b0, dREN & dWEN}, 32'b0);
            if (!pend) begin
               pend = 1; waitCnt = 0;
               pRen = dREN; pWen = dWEN; pAddr = daddr; pStore = dstore;
               case (waitMode)
                  1:       waitTarget = $urandom_range(0, 2);
                  2:       waitTarget = 4;
                  3:       waitTarget = (dWEN && daddr[2]) ? 1000000 : 0;
                  default: waitTarget = 0;
               endcase
            end else begin
               check("stable daddr", daddr, pAddr);
               check("stable dir", {30'b0, dREN, dWEN}, {30'b0, pRen, pWen});
               if (dWEN) check("stable dstore", dstore, pStore);
            end
            if (waitCnt < waitTarget) begin
               dwait = 1;
               waitCnt++;
            end else begin
               dwait = 0;
               pend  = 0;
               if (dREN) dload = memRd(daddr);
               if (xq.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected transfer: got addr %h wen %0d expected none", daddr, dWEN);
               end else begin
                  x = xq.pop_front();
                  check("xfer wr", {31'b0, dWEN}, {31'b0, x.wr});
                  check("xfer addr", daddr, x.addr);
                  if (x.wr) check("xfer data", dstore, x.data);
               end
               if (dWEN) mem[daddr] = dstore;
            end
         end else begin
            dwait = 0;
            pend  = 0;
         end
         if (dhit) begin
            hitSeen = 1;
            check("no transfer on hit", {30'b0, dREN, dWEN}, 32'b0);
            if (hq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected dhit: got dhit addr %h expected none", dmemaddr);
            end else begin
               check("dmemload", dmemload, hq.pop_front());
            end
         end else if (dmemREN || dmemWEN) begin
            check("dmemload zero without dhit", dmemload, 32'b0);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int unsigned op, ntr;
      bit found;

      nRST = 0; halt = 0; dmemREN = 0; dmemWEN = 0; dmemaddr = '0; dmemstore = '0;
      dwait = 0; dload = '0; waitMode = 0; hitSeen = 0;
      resetModel();
      mem[32'h40] = 32'hAAAA0001;    mem[32'h44] = 32'hAAAA0002;
      refMem[32'h40] = 32'hAAAA0001; refMem[32'h44] = 32'hAAAA0002;

      #12;
      check("reset dhit", {31'b0, dhit}, 32'b0);
      check("reset dREN/dWEN", {30'b0, dREN, dWEN}, 32'b0);
      check("reset daddr", daddr, 32'b0);
      check("reset dstore", dstore, 32'b0);
      check("reset flushed", {31'b0, flushed}, 32'b0);
      check("reset dmemload", dmemload, 32'b0);
      @(posedge CLK); #1 nRST = 1;
      @(posedge CLK); #1;

      doReq(1, 0, 32'h40,  '0,           1, "clean miss latency");
      doReq(1, 0, 32'h44,  '0,           1, "hit latency 0x44");
      doReq(0, 1, 32'h40,  32'h12345678, 1, "write hit latency");
      doReq(1, 0, 32'h440, '0,           1, "dirty miss latency");

      waitMode = 2;
      doReq(0, 1, 32'h840, 32'hCAFE0840, 1, "clean miss 4-wait latency");
      doReq(1, 0, 32'h40,  '0,           1, "dirty miss 4-wait latency");

      waitMode = 1;
      for (int i = 0; i < 200; i++) begin
         a = 32'($urandom_range(0, 3) * SETS * 8 * 5) + 32'($urandom_range(0, SETS - 1) * 8)
             + 32'($urandom_range(0, 7)) + ($urandom_range(0, 1) ? 32'h1000_0000 : 32'h0);
         op = $urandom_range(0, 2);
         doReq(op != 1, op != 0, a, $urandom, 0, "random");
      end

      // Reset while the second write-back word is stalled
      waitMode = 0;
      doReq(0, 1, 32'h40, 32'hDEAD0040, 0, "prime dirty 0x40");
      waitMode = 3;
      modelReq(0, 32'h440, '0, ntr);
      dmemREN = 1; dmemaddr = 32'h440;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK); #1;
         found = dWEN && (daddr == 32'h44);
      end
      check("reached WB1", {31'b0, found}, 32'd1);
      nRST = 0;
      #1;
      check("rst dhit", {31'b0, dhit}, 32'b0);
      check("rst dREN/dWEN", {30'b0, dREN, dWEN}, 32'b0);
      check("rst daddr", daddr, 32'b0);
      check("rst dstore", dstore, 32'b0);
      check("rst flushed", {31'b0, flushed}, 32'b0);
      check("rst dmemload", dmemload, 32'b0);
      dmemREN = 0;
      xq.delete(); hq.delete();
      resetModel();
      refMem = mem;
      waitMode = 0;
      @(posedge CLK); @(posedge CLK); #1 nRST = 1;
      @(posedge CLK); #1;

      // 3 hits, 2 misses, then flush
      doReq(1, 0, 32'h40, '0,           1, "post-reset miss 0x40");
      doReq(1, 0, 32'h44, '0,           1, "hit 0x44");
      doReq(0, 1, 32'h40, 32'h0BAD0040, 1, "write hit 0x40");
      doReq(1, 0, 32'h88, '0,           1, "miss 0x88");
      doReq(1, 1, 32'h8C, 32'h5EED008C, 1, "REN+WEN hit 0x8C");

      for (int i = 0; i < SETS; i++) begin
         if (mV[i] && mD[i]) begin
            a = (mT[i] * SETS + i) * 8;
            pushX(1'b1, a, mW[i][0]);
            pushX(1'b1, a + 32'd4, mW[i][1]);
         end
      end
      pushX(1'b1, 32'h0000_3100, mHits);
      halt = 1;
      found = 0;
      for (int i = 0; i < 500 && !found; i++) begin
         @(negedge CLK); #1;
         found = flushed;
      end
      check("flushed rises", {31'b0, flushed}, 32'd1);
      check("flush transfers drained", 32'(xq.size()), 32'd0);
      dmemREN = 1; dmemaddr = 32'h44;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK); #1;
         check("DONE dhit", {31'b0, dhit}, 32'b0);
         check("DONE flushed", {31'b0, flushed}, 32'd1);
      end
      dmemREN = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
